// File: rtl/uart_rx_sampler.sv
// 8N1 oversampling UART receiver: 2-flop input synchronizer, start-bit glitch
// rejection, 3-sample majority vote per bit, one-cycle valid / framing-error pulses.
module uart_rx_sampler #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  SAMP_A   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SAMP_B   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SAMP_C   = OS_W'(OVERSAMPLE / 2 + 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_rx_sampler: CLK_FREQ/(BAUD*OVERSAMPLE) must be >= 1");
        end
        if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
            $error("uart_rx_sampler: OVERSAMPLE must be even and >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [DIV_W-1:0] r_div_cnt;
    logic [OS_W-1:0]  r_os_cnt;
    logic [2:0]       r_bit_idx;
    logic [1:0]       r_samp;
    logic [7:0]       r_shreg;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;

    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [OS_W-1:0]  w_os_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [1:0]       w_samp_nxt;
    logic [7:0]       w_shreg_nxt;
    logic [7:0]       w_data_nxt;
    logic             w_valid_nxt;
    logic             w_frame_err_nxt;

    logic             w_rx;
    logic             w_tick;
    logic             w_os_wrap;
    logic             w_decide;
    logic             w_majority;

    assign w_rx       = r_sync2;
    assign w_tick     = (r_div_cnt == DIV_LAST);
    assign w_os_wrap  = w_tick && (r_os_cnt == OS_LAST);
    assign w_decide   = w_tick && (r_os_cnt == SAMP_C);
    // The third vote is the live synchronized sample taken on the decision tick.
    assign w_majority = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);

    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = w_tick ? '0 : r_div_cnt + 1'b1;
        w_os_nxt        = r_os_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_samp_nxt      = r_samp;
        w_shreg_nxt     = r_shreg;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;

        if (w_tick) begin
            w_os_nxt = w_os_wrap ? '0 : r_os_cnt + 1'b1;
            if (r_os_cnt == SAMP_A) w_samp_nxt[0] = w_rx;
            if (r_os_cnt == SAMP_B) w_samp_nxt[1] = w_rx;
        end

        case (r_state)
            S_IDLE: begin
                // Counters are held at zero so the bit grid is phase-aligned to the start edge.
                w_div_nxt = '0;
                w_os_nxt  = '0;
                if (!w_rx) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_decide && w_majority) begin
                    w_state_nxt = S_IDLE;
                end else if (w_os_wrap) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = 3'd0;
                end
            end
            S_DATA: begin
                if (w_decide) w_shreg_nxt[r_bit_idx] = w_majority;
                if (w_os_wrap) begin
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                    else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so a start bit that follows with no gap is caught.
                if (w_decide) begin
                    if (w_majority) begin
                        w_data_nxt  = r_shreg;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (w_rx) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_div_cnt   <= '0;
            r_os_cnt    <= '0;
            r_bit_idx   <= 3'd0;
            r_samp      <= 2'b00;
            r_shreg     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sync1     <= i_in;
            r_sync2     <= r_sync1;
            r_div_cnt   <= w_div_nxt;
            r_os_cnt    <= w_os_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_samp      <= w_samp_nxt;
            r_shreg     <= w_shreg_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != S_IDLE);

endmodule
